rom_boot_loader: RTL

Byte-serial program loader for `bean_mc_top`: accepts a framed program image on an 8-bit input port and writes it into the controller's instruction ROM regfile, replacing the `$readmemh` preload used in simulation. Sits directly upstream of the controller's ROM write port. Holds the controller in reset until a frame with a valid checksum has been written.

---
 rtl/rom_boot_loader_pkg.sv | 16 +
 rtl/rom_boot_loader_timeout_cnt.sv | 30 +++
 rtl/rom_boot_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rom_boot_loader_pkg.sv
// Shared constants and state encoding for the byte-serial ROM boot loader.
package rom_boot_loader_pkg;

    localparam int DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] BOOT_HDR = 8'hA5;

    typedef enum logic [2:0] {
        BL_IDLE = 3'd0,
        BL_LEN  = 3'd1,
        BL_DATA = 3'd2,
        BL_CHK  = 3'd3,
        BL_DONE = 3'd4,
        BL_ERR  = 3'd5
    } bl_state_t;

endpackage

// File: rtl/rom_boot_loader_timeout_cnt.sv
// Idle-cycle watchdog for an in-progress frame; expire is a combinational
// pulse in the cycle whose closing edge completes the TIMEOUT-th idle cycle.
module boot_timeout_cnt #(
    parameter int TIMEOUT = 1024
) (
    input  logic ref_clk,
    input  logic chip_rst_n,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] idle_cnt;

    assign expire = enable && !restart && (idle_cnt == LIMIT);

    always_ff @(posedge ref_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            idle_cnt <= '0;
        end else if (!enable || restart || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rom_boot_loader.sv
// Framed byte-serial program loader feeding the controller's ROM write port;
// holds the controller in reset until a frame with a good checksum lands.
module rom_boot_loader
    import rom_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  ref_clk,
    input  logic                  chip_rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    bl_state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [DATA_WIDTH-1:0] run_sum;
    logic [8:0]            bytes_left;
    logic                  timeout_expire;

    assign busy     = (state == BL_LEN) || (state == BL_DATA) || (state == BL_CHK);
    assign done     = (state == BL_DONE);
    assign error    = (state == BL_ERR);
    assign cpu_hold = (state != BL_DONE);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            boot_timeout_cnt #(
                .TIMEOUT (TIMEOUT)
            ) u_timeout (
                .ref_clk    (ref_clk),
                .chip_rst_n (chip_rst_n),
                .enable     (busy),
                .restart    (in_valid),
                .expire     (timeout_expire)
            );
        end else begin : g_no_timeout
            assign timeout_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge ref_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            state <= BL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A received byte always takes priority over an expiring idle count.
    always_comb begin
        state_next = state;
        case (state)
            BL_IDLE: begin
                if (in_valid && (in_data == BOOT_HDR)) state_next = BL_LEN;
            end
            BL_LEN: begin
                if (in_valid)            state_next = BL_DATA;
                else if (timeout_expire) state_next = BL_ERR;
            end
            BL_DATA: begin
                if (in_valid) begin
                    if (bytes_left == 9'd1) state_next = BL_CHK;
                end else if (timeout_expire) begin
                    state_next = BL_ERR;
                end
            end
            BL_CHK: begin
                if (in_valid)            state_next = (in_data == run_sum) ? BL_DONE : BL_ERR;
                else if (timeout_expire) state_next = BL_ERR;
            end
            BL_DONE, BL_ERR: begin
                if (in_valid && (in_data == BOOT_HDR)) state_next = BL_LEN;
            end
            default: state_next = BL_IDLE;
        endcase
    end

    // Length byte of zero stands for a full 256-byte payload.
    always_ff @(posedge ref_clk or negedge chip_rst_n) begin
        if (!chip_rst_n) begin
            in_ready   <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            addr_cnt   <= '0;
            run_sum    <= '0;
            bytes_left <= '0;
        end else begin
            in_ready <= 1'b1;
            rom_we   <= 1'b0;
            if (in_valid) begin
                case (state)
                    BL_LEN: begin
                        addr_cnt   <= '0;
                        run_sum    <= '0;
                        bytes_left <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    end
                    BL_DATA: begin
                        rom_we     <= 1'b1;
                        rom_addr   <= addr_cnt;
                        rom_wdata  <= in_data;
                        addr_cnt   <= addr_cnt + 1'b1;
                        run_sum    <= run_sum + in_data;
                        bytes_left <= bytes_left - 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
